// File: rtl/nanomamba_snr_pkg.sv
// rtl/nanomamba_snr_pkg.sv - shared state encoding and constants for the SNR scheduler
package nanomamba_snr_pkg;

    localparam int N_MELS       = 40;
    localparam int NOISE_FRAMES = 5;
    localparam int SNR_CLAMP    = 255;
    localparam int DEN_MIN      = 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_NOISE = 3'd1,
        S_RD    = 3'd2,
        S_WAIT  = 3'd3,
        S_DIV   = 3'd4,
        S_OUT   = 3'd5,
        S_FDONE = 3'd6
    } state_t;

    // Saturate a divider quotient into the 8-bit ratio field.
    function automatic logic [7:0] clamp_ratio(input logic [31:0] quot);
        return (quot > 32'(SNR_CLAMP)) ? 8'(SNR_CLAMP) : quot[7:0];
    endfunction

endpackage

// File: rtl/nanomamba_snr_scheduler.sv
// rtl/nanomamba_snr_scheduler.sv - per-frame mel band walker: noise init, then SNR ratios via shared divider
module nanomamba_snr_scheduler
    import nanomamba_snr_pkg::*;
#(
    parameter int N_MELS       = nanomamba_snr_pkg::N_MELS,
    parameter int NOISE_FRAMES = nanomamba_snr_pkg::NOISE_FRAMES
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_done,
    output logic        mel_rd_en,
    output logic [5:0]  mel_rd_addr,
    input  logic [31:0] mel_energy,
    input  logic [15:0] noise_floor,
    output logic        nf_upd_en,
    output logic [5:0]  nf_upd_addr,
    output logic        div_start,
    output logic [31:0] div_num,
    output logic [15:0] div_den,
    input  logic        div_done,
    input  logic [31:0] div_quot,
    output logic [7:0]  snr_ratio,
    output logic [5:0]  snr_index,
    output logic        snr_valid,
    input  logic        snr_ready,
    output logic        snr_frame_done,
    output logic        noise_init_done,
    output logic        overrun
);

    localparam logic [5:0] LAST_BAND = 6'(N_MELS - 1);
    localparam int         FC_W      = (NOISE_FRAMES < 2) ? 1 : $clog2(NOISE_FRAMES + 1);
    localparam logic [FC_W-1:0] FC_MAX = FC_W'(NOISE_FRAMES);

    state_t            state;
    state_t            state_nx;
    logic [5:0]        band;
    logic [FC_W-1:0]   frame_count;
    logic [FC_W-1:0]   frame_count_nx;
    logic              init_done_q;
    logic              overrun_q;
    logic              div_issued;
    logic [31:0]       energy_q;
    logic [15:0]       den_q;
    logic [7:0]        ratio_q;
    logic [5:0]        index_q;
    logic              last_band;
    logic              accept;

    assign last_band      = (band == LAST_BAND);
    assign accept         = (state == S_OUT) && snr_ready;
    assign frame_count_nx = (frame_count == FC_MAX) ? frame_count : frame_count + FC_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (frame_done) state_nx = init_done_q ? S_RD : S_NOISE;
            S_NOISE: if (last_band) state_nx = S_IDLE;
            S_RD:    state_nx = S_WAIT;
            S_WAIT:  state_nx = S_DIV;
            S_DIV:   if (div_done) state_nx = S_OUT;
            S_OUT:   if (snr_ready) state_nx = last_band ? S_FDONE : S_RD;
            S_FDONE: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        mel_rd_en      = (state == S_RD);
        nf_upd_en      = (state == S_NOISE) || accept;
        div_start      = (state == S_DIV) && !div_issued;
        snr_valid      = (state == S_OUT);
        snr_frame_done = (state == S_FDONE);
    end

    assign mel_rd_addr     = band;
    assign nf_upd_addr     = band;
    assign div_num         = energy_q;
    assign div_den         = den_q;
    assign snr_ratio       = ratio_q;
    assign snr_index       = index_q;
    assign noise_init_done = init_done_q;
    assign overrun         = overrun_q;

    // Band pointer and frame bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            band        <= 6'd0;
            frame_count <= '0;
            init_done_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            if (frame_done && state != S_IDLE) begin
                overrun_q <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (frame_done) band <= 6'd0;
                end
                S_NOISE: begin
                    if (last_band) begin
                        band        <= 6'd0;
                        frame_count <= frame_count_nx;
                        if (frame_count_nx == FC_MAX) init_done_q <= 1'b1;
                    end else begin
                        band <= band + 6'd1;
                    end
                end
                S_OUT: begin
                    if (snr_ready && !last_band) band <= band + 6'd1;
                end
                default: ;
            endcase
        end
    end

    // Operand capture, divider handshake and result register.
    // A zero floor is replaced so the divider never sees a zero denominator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            energy_q   <= 32'd0;
            den_q      <= 16'd0;
            div_issued <= 1'b0;
            ratio_q    <= 8'd0;
            index_q    <= 6'd0;
        end else begin
            div_issued <= (state == S_DIV);
            if (state == S_WAIT) begin
                energy_q <= mel_energy;
                den_q    <= (noise_floor == 16'd0) ? 16'(DEN_MIN) : noise_floor;
            end
            if (state == S_DIV && div_done) begin
                ratio_q <= clamp_ratio(div_quot);
                index_q <= band;
            end
        end
    end

endmodule

// File: tb/tb_nanomamba_snr_scheduler.sv
// tb/tb_nanomamba_snr_scheduler.sv - scoreboard bench for nanomamba_snr_scheduler
module tb_nanomamba_snr_scheduler;

    localparam int NB = 40;

    logic        clk;
    logic        rst_n;
    logic        frame_done;
    logic        mel_rd_en;
    logic [5:0]  mel_rd_addr;
    logic [31:0] mel_energy;
    logic [15:0] noise_floor;
    logic        nf_upd_en;
    logic [5:0]  nf_upd_addr;
    logic        div_start;
    logic [31:0] div_num;
    logic [15:0] div_den;
    logic        div_done;
    logic [31:0] div_quot;
    logic [7:0]  snr_ratio;
    logic [5:0]  snr_index;
    logic        snr_valid;
    logic        snr_ready;
    logic        snr_frame_done;
    logic        noise_init_done;
    logic        overrun;

    nanomamba_snr_scheduler dut (
        .clk(clk), .rst_n(rst_n), .frame_done(frame_done),
        .mel_rd_en(mel_rd_en), .mel_rd_addr(mel_rd_addr),
        .mel_energy(mel_energy), .noise_floor(noise_floor),
        .nf_upd_en(nf_upd_en), .nf_upd_addr(nf_upd_addr),
        .div_start(div_start), .div_num(div_num), .div_den(div_den),
        .div_done(div_done), .div_quot(div_quot),
        .snr_ratio(snr_ratio), .snr_index(snr_index),
        .snr_valid(snr_valid), .snr_ready(snr_ready),
        .snr_frame_done(snr_frame_done), .noise_init_done(noise_init_done),
        .overrun(overrun)
    );

    int n_checks = 0;
    int n_fail   = 0;

    int nf_q[$];
    int snr_idx_q[$];
    int snr_ratio_q[$];

    int e_mem[64];
    int f_mem[64];
    int last_a       = 0;
    int rd_next      = 0;
    int div_lat      = 2;
    int spur_req     = 0;
    int spur_ack     = 0;
    int fd_cnt       = 0;
    int div_cnt      = 0;
    int valid_cnt    = 0;
    int beat_cnt     = 0;
    bit hold_ready   = 0;
    bit stall_arm    = 0;
    bit stall_done   = 0;
    int stall_idx    = 5;
    int stall_ratio  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int exp_ratio(input int e, input int f);
        int d;
        int q;
        d = (f == 0) ? 1 : f;
        q = e / d;
        return (q > 255) ? 255 : q;
    endfunction

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // Output monitor: pops the scoreboards on nf updates and accepted beats.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (rst_n) begin
                if (nf_upd_en) begin
                    if (nf_q.size() == 0) check("nf_unexpected", 32'(nf_upd_addr), 32'hffff_ffff);
                    else check("nf_addr", 32'(nf_upd_addr), 32'(nf_q.pop_front()));
                end
                if (snr_valid) valid_cnt++;
                if (snr_valid && snr_ready) begin
                    beat_cnt++;
                    if (snr_idx_q.size() == 0) begin
                        check("snr_unexpected", 32'(snr_index), 32'hffff_ffff);
                    end else begin
                        check("snr_index", 32'(snr_index), 32'(snr_idx_q.pop_front()));
                        check("snr_ratio", 32'(snr_ratio), 32'(snr_ratio_q.pop_front()));
                    end
                end
                if (snr_frame_done) fd_cnt++;
                if (div_start) div_cnt++;
            end
        end
    end

    // Band store: data appears one cycle after the read strobe, garbage otherwise.
    initial begin
        int a;
        mel_energy  = 32'd0;
        noise_floor = 16'd0;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n && mel_rd_en) begin
                a = int'(mel_rd_addr);
                check("rd_addr", 32'(a), 32'(rd_next));
                rd_next = (rd_next + 1) % NB;
                last_a  = a;
                @(posedge clk);
                #1;
                mel_energy  = 32'(e_mem[a]);
                noise_floor = 16'(f_mem[a]);
                @(posedge clk);
                #1;
                mel_energy  = 32'hdead_beef;
                noise_floor = 16'h5a5a;
            end
        end
    end

    // Divider model with configurable latency and optional stray completions.
    initial begin
        int q;
        int d;
        div_done = 0;
        div_quot = 0;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n && div_start) begin
                d = (f_mem[last_a] == 0) ? 1 : f_mem[last_a];
                check("div_num", div_num, 32'(e_mem[last_a]));
                check("div_den", 32'(div_den), 32'(d));
                q = int'(div_num) / ((div_den == 16'd0) ? 1 : int'(div_den));
                repeat (div_lat) @(negedge clk);
                div_quot = 32'(q);
                div_done = 1;
                @(negedge clk);
                div_done = 0;
            end else if (spur_req != spur_ack) begin
                div_quot = 32'd77;
                div_done = 1;
                @(negedge clk);
                div_done = 0;
                spur_ack++;
            end
        end
    end

    // Ready driver: optional held-low window on one band with stability checks.
    initial begin
        snr_ready = 1;
        forever begin
            @(negedge clk);
            if (hold_ready) begin
                snr_ready = 0;
            end else if (stall_arm && !stall_done && snr_valid && int'(snr_index) == stall_idx) begin
                snr_ready = 0;
                for (int i = 0; i < 7; i++) begin
                    #1;
                    check("bp_valid", 32'(snr_valid), 32'd1);
                    check("bp_index", 32'(snr_index), 32'(stall_idx));
                    check("bp_ratio", 32'(snr_ratio), 32'(stall_ratio));
                    check("bp_nf_quiet", 32'(nf_upd_en), 32'd0);
                    @(negedge clk);
                end
                snr_ready  = 1;
                stall_done = 1;
            end else begin
                snr_ready = 1;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic pulse_frame();
        @(negedge clk);
        frame_done = 1;
        @(negedge clk);
        frame_done = 0;
    endtask

    task automatic wait_nf_empty(input string tag);
        int n;
        n = 0;
        while (nf_q.size() != 0 && n < 500) begin
            tick();
            n++;
        end
        check(tag, 32'(nf_q.size()), 32'd0);
    endtask

    task automatic wait_fd(input int target, input string tag);
        int n;
        n = 0;
        while (fd_cnt < target && n < 4000) begin
            tick();
            n++;
        end
        check(tag, 32'(fd_cnt >= target), 32'd1);
    endtask

    task automatic load_snr_frame();
        for (int b = 0; b < NB; b++) begin
            snr_idx_q.push_back(b);
            snr_ratio_q.push_back(exp_ratio(e_mem[b], f_mem[b]));
            nf_q.push_back(b);
        end
    endtask

    initial begin
        int fd0;
        int dc0;
        int bc0;
        int vc0;
        rst_n      = 0;
        frame_done = 0;
        for (int b = 0; b < 64; b++) begin
            e_mem[b] = 0;
            f_mem[b] = 1;
        end

        repeat (3) @(negedge clk);
        #1;
        check("reset_outputs", {mel_rd_en, nf_upd_en, div_start, snr_valid, snr_frame_done,
                                noise_init_done, overrun, snr_ratio, snr_index, div_den},
              32'd0);
        @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_quiet", {25'd0, mel_rd_en, nf_upd_en, div_start, snr_valid,
                                 snr_frame_done, noise_init_done, overrun}, 32'd0);
        end

        // Noise initialisation frames
        for (int f = 0; f < 5; f++) begin
            for (int b = 0; b < NB; b++) nf_q.push_back(b);
            pulse_frame();
            wait_nf_empty("noise_frame_timeout");
            tick();
            check("noise_init_done", 32'(noise_init_done), (f == 4) ? 32'd1 : 32'd0);
        end
        check("noise_no_valid", 32'(valid_cnt), 32'd0);

        // Nominal SNR frame: 1000/10 -> 100
        for (int b = 0; b < NB; b++) begin
            e_mem[b] = 1000;
            f_mem[b] = 10;
        end
        load_snr_frame();
        fd0 = fd_cnt;
        dc0 = div_cnt;
        bc0 = beat_cnt;
        pulse_frame();
        wait_fd(fd0 + 1, "snr_frame_timeout");
        tick();
        check("snr_frame_done_cnt", 32'(fd_cnt - fd0), 32'd1);
        check("snr_beats", 32'(beat_cnt - bc0), 32'd40);
        check("div_starts", 32'(div_cnt - dc0), 32'd40);
        check("snr_q_empty", 32'(snr_idx_q.size()), 32'd0);
        check("nf_q_empty", 32'(nf_q.size()), 32'd0);
        check("overrun_clear", 32'(overrun), 32'd0);

        // Stray divider completion in IDLE must be ignored
        vc0 = valid_cnt;
        spur_req++;
        repeat (4) tick();
        check("spur_no_valid", 32'(valid_cnt - vc0), 32'd0);
        check("spur_acked", 32'(spur_ack), 32'(spur_req));

        // Boundary operands plus a backpressure window
        e_mem[0] = 300;  f_mem[0] = 0;
        e_mem[1] = 0;    f_mem[1] = 0;
        e_mem[2] = 1785; f_mem[2] = 7;
        e_mem[3] = 764;  f_mem[3] = 3;
        for (int b = 4; b < NB; b++) begin
            e_mem[b] = int'($urandom_range(0, 5000));
            f_mem[b] = int'($urandom_range(0, 40));
        end
        stall_ratio = exp_ratio(e_mem[stall_idx], f_mem[stall_idx]);
        stall_arm   = 1;
        div_lat     = 3;
        load_snr_frame();
        fd0 = fd_cnt;
        pulse_frame();
        wait_fd(fd0 + 1, "boundary_frame_timeout");
        tick();
        check("stall_happened", 32'(stall_done), 32'd1);
        check("bnd_snr_q_empty", 32'(snr_idx_q.size()), 32'd0);
        check("bnd_nf_q_empty", 32'(nf_q.size()), 32'd0);
        check("overrun_still_clear", 32'(overrun), 32'd0);

        // frame_done coinciding with div_done during DIV
        for (int b = 0; b < NB; b++) begin
            e_mem[b] = 5000;
            f_mem[b] = 25;
        end
        div_lat = 4;
        load_snr_frame();
        fd0 = fd_cnt;
        pulse_frame();
        begin
            int n;
            n = 0;
            while (div_done !== 1'b1 && n < 200) begin
                tick();
                n++;
            end
            check("div_done_seen", 32'(div_done), 32'd1);
        end
        frame_done = 1;
        @(negedge clk);
        frame_done = 0;
        tick();
        check("overrun_set", 32'(overrun), 32'd1);
        wait_fd(fd0 + 1, "overrun_frame_timeout");
        tick();
        check("ovr_frame_done_cnt", 32'(fd_cnt - fd0), 32'd1);
        check("ovr_snr_q_empty", 32'(snr_idx_q.size()), 32'd0);
        check("overrun_sticky", 32'(overrun), 32'd1);

        // Reset in the middle of OUT
        hold_ready = 1;
        div_lat    = 1;
        pulse_frame();
        begin
            int n;
            n = 0;
            while (snr_valid !== 1'b1 && n < 200) begin
                tick();
                n++;
            end
            check("reached_out", 32'(snr_valid), 32'd1);
        end
        rst_n = 0;
        #1;
        check("rst_valid", 32'(snr_valid), 32'd0);
        check("rst_init_done", 32'(noise_init_done), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_nf", 32'(nf_upd_en), 32'd0);
        nf_q.delete();
        snr_idx_q.delete();
        snr_ratio_q.delete();
        tick();
        rst_n      = 1;
        hold_ready = 0;
        fd0 = fd_cnt;
        vc0 = valid_cnt;
        repeat (5) tick();
        check("rst_no_frame_done", 32'(fd_cnt - fd0), 32'd0);

        // First frame after reset restarts noise initialisation
        for (int b = 0; b < NB; b++) nf_q.push_back(b);
        pulse_frame();
        wait_nf_empty("post_reset_noise_timeout");
        tick();
        check("post_reset_init_done", 32'(noise_init_done), 32'd0);
        check("post_reset_no_valid", 32'(valid_cnt - vc0), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
